cve2_sleep_ctrl: RTL and testbench
==================================

CVE2_SLEEP_CTRL -- requirements
Module: cve2_sleep_ctrl

Interface
REQ-001 SHALL have parameter NumWakeSrc, default 4: number of independent wake sources, range 1..32.
REQ-002 SHALL have parameter IdleHoldCycles, default 4: consecutive idle cycles required before gating, range 0..255.
REQ-003 SHALL have parameter WakeHoldCycles, default 2: minimum enabled cycles after a wake, range 1..255.
REQ-004 SHALL have parameter CntWidth, default 32: width of the sleep-cycle counter, range 8..64.
REQ-005 SHALL have port clk_i, input, 1: free-running clock.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port test_en_i, input, 1: forces the gated clock on for test.
REQ-008 SHALL have port core_busy_i, input, 1: core busy indication.
REQ-009 SHALL have port wake_src_i, input, NumWakeSrc: wake requests (irq, nmi, debug, ...), level-sensitive.
REQ-010 SHALL have port wake_mask_i, input, NumWakeSrc: per-source enable, 1 = source may wake.
REQ-011 SHALL have port cnt_clr_i, input, 1: synchronous clear of the sleep counter.
REQ-012 SHALL have port clk_o, output, 1: gated core clock.
REQ-013 SHALL have port clock_en_o, output, 1: gate enable.
REQ-014 SHALL have port core_sleep_o, output, 1: equals ~clock_en_o.
REQ-015 SHALL have port sleep_cycles_o, output, CntWidth: saturating count of gated cycles.

Function
REQ-016 wake_any SHALL be the OR of (wake_src_i & wake_mask_i).
REQ-017 The FSM SHALL have four states: RUN, IDLE, SLEEP, WAKE.
REQ-018 RUN: if !core_busy_i and !wake_any, the FSM SHALL go to SLEEP when IdleHoldCycles==0; otherwise it SHALL go to IDLE and load the counter with IdleHoldCycles-1.
REQ-019 IDLE: core_busy_i or wake_any SHALL return the FSM to RUN; otherwise, when the counter is 0 the FSM SHALL go to SLEEP, else the counter SHALL decrement.
REQ-020 SLEEP: wake_any SHALL move the FSM to WAKE and load the counter with WakeHoldCycles-1; core_busy_i SHALL be ignored in SLEEP.
REQ-021 WAKE: the counter SHALL decrement to 0 and the FSM SHALL then go to RUN; wake and busy inputs SHALL NOT shorten WAKE.
REQ-022 clock_en_o SHALL be (state != SLEEP) | wake_any, combinationally, giving zero-cycle wake latency.
REQ-023 Gating SHALL start exactly IdleHoldCycles+1 cycles after the first cycle in which core_busy_i is low with no wake, assuming idle is held throughout.
REQ-024 sleep_cycles_o SHALL increment by 1 on each clk_i edge where state==SLEEP and clock_en_o==0.
REQ-025 sleep_cycles_o SHALL saturate at all-ones.
REQ-026 cnt_clr_i SHALL have priority over increment.
REQ-027 Simultaneous final IDLE count and wake_any SHALL result in RUN, never SLEEP.
REQ-028 A wake source masked mid-SLEEP SHALL NOT wake; unmasking an active source SHALL wake in the same cycle.
REQ-029 All FSM and counter registers SHALL be clocked by clk_i, never by clk_o.
REQ-030 clk_o SHALL be produced by a single clock-gating cell with enable clock_en_o and test_en_i.

Reset
REQ-031 On reset assertion, state SHALL be RUN, the counter 0, and sleep_cycles_o 0.
REQ-032 During reset, clock_en_o SHALL be 1 and core_sleep_o 0.
REQ-033 Reset mid-SLEEP or mid-WAKE SHALL immediately re-enable the clock asynchronously.
REQ-034 The count SHALL restart fully after reset release.

Structure
REQ-035 typedef sleep_state_e {RUN, IDLE, SLEEP, WAKE} SHALL live in cve2_pkg.
REQ-036 The default parameter constants SHALL live in cve2_pkg.
REQ-037 The sole sub-module SHALL be prim_clock_gating.
REQ-038 The block SHALL replace the core-busy flop and gate in cve2_top, wiring irq_pending, irq_nm_i and debug_req_i as wake sources.
REQ-039 Parameter-range assertions SHALL be present.
REQ-040 X-check assertions on all inputs SHALL be present.

Verification
REQ-041 Defaults, busy 1->0 at cycle 10, no wake -> clock_en_o falls at cycle 15, sleep_cycles_o counts 1,2,3...
REQ-042 SLEEP, wake_src_i=4'b0010 with mask 4'b1111 -> clock_en_o=1 same cycle; state WAKE 2 cycles, then RUN.
REQ-043 IDLE with counter 0 and wake_src_i[0] pulse the same cycle -> state RUN, clock_en_o never 0.
REQ-044 SLEEP, wake_src_i=4'b1000, mask=4'b0111 -> stays SLEEP; set mask[3] -> wake same cycle.
REQ-045 CntWidth=8, sleep 300 cycles -> sleep_cycles_o=8'hFF; cnt_clr_i with SLEEP -> next value 0.
REQ-046 rst_ni low during SLEEP -> clock_en_o=1 immediately; after release state RUN, count 0; test_en_i=1 in SLEEP -> clk_o toggles.

Source files
------------

// File: rtl/cve2_pkg.sv
// Shared sleep-controller types and default parameter values for the cve2 core.
// Pure declarations: no logic, no latency, no flow control.
package cve2_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IDLE  = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } sleep_state_e;

    localparam int unsigned SleepNumWakeSrc     = 4;
    localparam int unsigned SleepIdleHoldCycles = 4;
    localparam int unsigned SleepWakeHoldCycles = 2;
    localparam int unsigned SleepCntWidth       = 32;

    // Hold counters are loaded with N-1 so a hold of N spends exactly N cycles in the state.
    function automatic logic [7:0] hold_load(int unsigned cycles);
        return (cycles == 0) ? 8'd0 : 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/prim_clock_gating.sv
// Latch-based integrated clock gate: enable captured while clk_i is low, so clk_o never glitches.
// Enable changes take effect from the next rising edge; no flow control.
module prim_clock_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic en_latch;

    always_latch begin
        if (!clk_i) begin
            en_latch = en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_latch;

endmodule

// File: rtl/cve2_sleep_ctrl.sv
// Core sleep controller: gates the core clock after a run of idle cycles, wakes with zero latency.
// Wake sources are level-sensitive and masked per source; no backpressure, all state on clk_i.
module cve2_sleep_ctrl
    import cve2_pkg::*;
#(
    parameter int unsigned NumWakeSrc     = SleepNumWakeSrc,
    parameter int unsigned IdleHoldCycles = SleepIdleHoldCycles,
    parameter int unsigned WakeHoldCycles = SleepWakeHoldCycles,
    parameter int unsigned CntWidth       = SleepCntWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_en_i,
    input  logic                  core_busy_i,
    input  logic [NumWakeSrc-1:0] wake_src_i,
    input  logic [NumWakeSrc-1:0] wake_mask_i,
    input  logic                  cnt_clr_i,
    output logic                  clk_o,
    output logic                  clock_en_o,
    output logic                  core_sleep_o,
    output logic [CntWidth-1:0]   sleep_cycles_o
);

    localparam logic [7:0] IdleLoad = hold_load(IdleHoldCycles);
    localparam logic [7:0] WakeLoad = hold_load(WakeHoldCycles);

    sleep_state_e        state_q;
    logic [7:0]          hold_cnt_q;
    logic [CntWidth-1:0] sleep_cnt_q;
    logic                wake_any;

    assign wake_any = |(wake_src_i & wake_mask_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            hold_cnt_q <= 8'd0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!core_busy_i && !wake_any) begin
                        if (IdleHoldCycles == 0) begin
                            state_q <= SLEEP;
                        end else begin
                            state_q    <= IDLE;
                            hold_cnt_q <= IdleLoad;
                        end
                    end
                end
                IDLE: begin
                    // A wake arriving on the final idle count must win over entering SLEEP.
                    if (core_busy_i || wake_any) begin
                        state_q <= RUN;
                    end else if (hold_cnt_q == 8'd0) begin
                        state_q <= SLEEP;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 8'd1;
                    end
                end
                SLEEP: begin
                    if (wake_any) begin
                        state_q    <= WAKE;
                        hold_cnt_q <= WakeLoad;
                    end
                end
                WAKE: begin
                    if (hold_cnt_q == 8'd0) begin
                        state_q <= RUN;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    // Combinational wake path so the first wake cycle is already clocked.
    assign clock_en_o   = (state_q != SLEEP) | wake_any;
    assign core_sleep_o = ~clock_en_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sleep_cnt_q <= '0;
        end else if (cnt_clr_i) begin
            sleep_cnt_q <= '0;
        end else if ((state_q == SLEEP) && !clock_en_o && (sleep_cnt_q != '1)) begin
            sleep_cnt_q <= sleep_cnt_q + CntWidth'(1);
        end
    end

    assign sleep_cycles_o = sleep_cnt_q;

    prim_clock_gating u_clk_gate (
        .clk_i     (clk_i),
        .en_i      (clock_en_o),
        .test_en_i (test_en_i),
        .clk_o     (clk_o)
    );

`ifndef SYNTHESIS
    ParamRange_A: assert property (@(posedge clk_i)
        (NumWakeSrc >= 1) && (NumWakeSrc <= 32) &&
        (IdleHoldCycles <= 255) &&
        (WakeHoldCycles >= 1) && (WakeHoldCycles <= 255) &&
        (CntWidth >= 8) && (CntWidth <= 64));

    RstKnown_A: assert property (@(posedge clk_i) !$isunknown(rst_ni));

    InputsKnown_A: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({test_en_i, core_busy_i, wake_src_i, wake_mask_i, cnt_clr_i}));
`endif

endmodule

// File: tb/tb_cve2_sleep_ctrl.sv
// Scenario bench for cve2_sleep_ctrl against a cycle-count model of the sleep rules.
module tb_cve2_sleep_ctrl;

    localparam int IDLE_HOLD = 4;
    localparam int WAKE_HOLD = 2;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       test_en = 1'b0;
    logic       busy    = 1'b1;
    logic       clr     = 1'b0;
    logic [3:0] src     = 4'h0;
    logic [3:0] mask    = 4'hF;

    logic        clk_o, en, sleep_o;
    logic [31:0] cnt;
    logic        clk_o8, en8, sleep8;
    logic [7:0]  cnt8;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    cve2_sleep_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en), .core_busy_i(busy),
        .wake_src_i(src), .wake_mask_i(mask), .cnt_clr_i(clr),
        .clk_o(clk_o), .clock_en_o(en), .core_sleep_o(sleep_o), .sleep_cycles_o(cnt)
    );

    cve2_sleep_ctrl #(.CntWidth(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en), .core_busy_i(busy),
        .wake_src_i(src), .wake_mask_i(mask), .cnt_clr_i(clr),
        .clk_o(clk_o8), .clock_en_o(en8), .core_sleep_o(sleep8), .sleep_cycles_o(cnt8)
    );

    // Reference: sleep after IDLE_HOLD+1 consecutive idle cycles, wake hold counted down, counters saturate.
    bit              m_asleep    = 0;
    int              m_wake_left = 0;
    int              m_idle      = 0;
    longint unsigned m_cnt       = 0;
    int              m_cnt8      = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit w;
        if (!rst_n) begin
            m_asleep = 0; m_wake_left = 0; m_idle = 0; m_cnt = 0; m_cnt8 = 0;
        end else begin
            w = |(src & mask);
            if (clr) begin
                m_cnt = 0; m_cnt8 = 0;
            end else if (m_asleep && !w) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (m_cnt8 < 255) m_cnt8++;
            end
            if (m_asleep) begin
                if (w) begin m_asleep = 0; m_wake_left = WAKE_HOLD; m_idle = 0; end
            end else if (m_wake_left > 0) begin
                m_wake_left--;
            end else if (busy || w) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == IDLE_HOLD + 1) begin m_asleep = 1; m_idle = 0; end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        busy = 1'b0;
        repeat (3) tick();
        cmp_cnt++; if (en !== 1'b1) begin err_cnt++; $display("FAIL reset_en: got %b want 1", en); end
        cmp_cnt++; if (sleep_o !== 1'b0) begin err_cnt++; $display("FAIL reset_sleep: got %b want 0", sleep_o); end
        cmp_cnt++; if (cnt !== 32'd0) begin err_cnt++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        cmp_cnt++; if (cnt8 !== 8'd0) begin err_cnt++; $display("FAIL reset_cnt8: got %0d want 0", cnt8); end
        busy = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        cmp_cnt++; if (en !== 1'b1) begin err_cnt++; $display("FAIL post_reset_en: got %b want 1", en); end
    endtask

    task automatic test_idle_entry();
        repeat (10) tick();
        busy = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            cmp_cnt++; if (en !== (i < 5)) begin err_cnt++; $display("FAIL idle_entry_en[%0d]: got %b want %b", i, en, (i < 5)); end
            cmp_cnt++; if (sleep_o !== ~en) begin err_cnt++; $display("FAIL idle_entry_sleep[%0d]: got %b want %b", i, sleep_o, ~en); end
            if (i >= 5) begin
                cmp_cnt++; if (cnt !== 32'(i - 5)) begin err_cnt++; $display("FAIL idle_entry_cnt[%0d]: got %0d want %0d", i, cnt, i - 5); end
            end
        end
    endtask

    task automatic test_wake();
        src = 4'b0010; mask = 4'hF;
        #1;
        cmp_cnt++; if (en !== 1'b1) begin err_cnt++; $display("FAIL wake_same_cycle: got %b want 1", en); end
        tick();
        src = 4'b0000;
        for (int j = 1; j <= 8; j++) begin
            tick();
            cmp_cnt++; if (en !== (j < 7)) begin err_cnt++; $display("FAIL wake_hold_en[%0d]: got %b want %b", j, en, (j < 7)); end
            cmp_cnt++; if (cnt !== (j < 8 ? 32'd3 : 32'd4)) begin err_cnt++; $display("FAIL wake_hold_cnt[%0d]: got %0d want %0d", j, cnt, (j < 8 ? 3 : 4)); end
        end
    endtask

    task automatic test_idle_wake_race();
        busy = 1'b1; src = 4'b0001;
        tick();
        src = 4'b0000;
        repeat (3) tick();
        busy = 1'b0;
        repeat (4) tick();
        src = 4'b0001;
        #1;
        cmp_cnt++; if (en !== 1'b1) begin err_cnt++; $display("FAIL race_en_pre: got %b want 1", en); end
        tick();
        src = 4'b0000;
        for (int k = 1; k <= 5; k++) begin
            tick();
            cmp_cnt++; if (en !== (k < 5)) begin err_cnt++; $display("FAIL race_en[%0d]: got %b want %b", k, en, (k < 5)); end
        end
    endtask

    task automatic test_mask();
        logic [31:0] base;
        src = 4'b1000; mask = 4'b0111;
        #1;
        base = cnt;
        cmp_cnt++; if (en !== 1'b0) begin err_cnt++; $display("FAIL mask_blocked: got %b want 0", en); end
        repeat (3) tick();
        cmp_cnt++; if (en !== 1'b0) begin err_cnt++; $display("FAIL mask_stay: got %b want 0", en); end
        cmp_cnt++; if (cnt !== base + 32'd3) begin err_cnt++; $display("FAIL mask_cnt: got %0d want %0d", cnt, base + 32'd3); end
        mask = 4'b1111;
        #1;
        cmp_cnt++; if (en !== 1'b1) begin err_cnt++; $display("FAIL unmask_wake: got %b want 1", en); end
        tick();
        src = 4'b0000;
    endtask

    task automatic test_saturate();
        int guard = 0;
        busy = 1'b0; src = 4'b0000; mask = 4'hF;
        while (!m_asleep && guard < 20) begin tick(); guard++; end
        cmp_cnt++; if (en !== 1'b0) begin err_cnt++; $display("FAIL sat_asleep: got %b want 0 after %0d cycles", en, guard); end
        repeat (300) tick();
        cmp_cnt++; if (cnt8 !== 8'hFF) begin err_cnt++; $display("FAIL sat_cnt8: got %h want ff", cnt8); end
        cmp_cnt++; if (cnt !== m_cnt[31:0]) begin err_cnt++; $display("FAIL sat_cnt32: got %0d want %0d", cnt, m_cnt); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cmp_cnt++; if (cnt8 !== 8'd0) begin err_cnt++; $display("FAIL clr_cnt8: got %0d want 0", cnt8); end
        cmp_cnt++; if (cnt !== 32'd0) begin err_cnt++; $display("FAIL clr_cnt32: got %0d want 0", cnt); end
        tick();
        cmp_cnt++; if (cnt8 !== 8'd1) begin err_cnt++; $display("FAIL clr_resume: got %0d want 1", cnt8); end
    endtask

    task automatic test_reset_sleep();
        rst_n = 1'b0;
        #1;
        cmp_cnt++; if (en !== 1'b1) begin err_cnt++; $display("FAIL rst_sleep_en: got %b want 1", en); end
        cmp_cnt++; if (sleep8 !== 1'b0) begin err_cnt++; $display("FAIL rst_sleep8: got %b want 0", sleep8); end
        cmp_cnt++; if (cnt !== 32'd0) begin err_cnt++; $display("FAIL rst_sleep_cnt: got %0d want 0", cnt); end
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            cmp_cnt++; if (en8 !== (i < 5)) begin err_cnt++; $display("FAIL restart_en[%0d]: got %b want %b", i, en8, (i < 5)); end
            cmp_cnt++; if (cnt !== 32'(i < 6 ? 0 : 1)) begin err_cnt++; $display("FAIL restart_cnt[%0d]: got %0d want %0d", i, cnt, (i < 6 ? 0 : 1)); end
        end
        tick();
        cmp_cnt++; if (clk_o !== 1'b0) begin err_cnt++; $display("FAIL gated_clk: got %b want 0", clk_o); end
        test_en = 1'b1;
        tick();
        cmp_cnt++; if (clk_o !== 1'b1) begin err_cnt++; $display("FAIL test_en_high: got %b want 1", clk_o); end
        cmp_cnt++; if (clk_o8 !== 1'b1) begin err_cnt++; $display("FAIL test_en_high8: got %b want 1", clk_o8); end
        #5;
        cmp_cnt++; if (clk_o !== 1'b0) begin err_cnt++; $display("FAIL test_en_low: got %b want 0", clk_o); end
        test_en = 1'b0;
    endtask

    task automatic test_random();
        logic exp_en;
        for (int n = 0; n < 3000; n++) begin
            busy = ($urandom_range(0, 9) == 0);
            for (int b = 0; b < 4; b++) src[b] = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) mask = 4'($urandom_range(0, 15));
            clr = ($urandom_range(0, 199) == 0);
            test_en = ($urandom_range(0, 9) == 0);
            tick();
            exp_en = !m_asleep || (|(src & mask));
            cmp_cnt++; if (en !== exp_en) begin err_cnt++; $display("FAIL rand_en[%0d]: got %b want %b", n, en, exp_en); end
            cmp_cnt++; if (sleep8 !== ~exp_en) begin err_cnt++; $display("FAIL rand_sleep[%0d]: got %b want %b", n, sleep8, ~exp_en); end
            cmp_cnt++; if (cnt !== m_cnt[31:0]) begin err_cnt++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", n, cnt, m_cnt); end
            cmp_cnt++; if (cnt8 !== 8'(m_cnt8)) begin err_cnt++; $display("FAIL rand_cnt8[%0d]: got %0d want %0d", n, cnt8, m_cnt8); end
        end
        clr = 1'b0; test_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_entry();
        test_wake();
        test_idle_wake_race();
        test_mask();
        test_saturate();
        test_reset_sleep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
